// File: rtl/gps_bridge_pkg.sv
// Shared definitions for the GPS-to-MCU bridge.
// Sample/byte widths, nibble bit order, FIFO entry layout.
package gps_bridge_pkg;

    localparam int SAMPLE_W        = 4;
    localparam int BYTE_W          = 8;
    localparam int FRAME_BYTES_DEF = 512;

    // Bit positions of the front-end bits inside one sample nibble
    localparam int NIB_I1 = 3;
    localparam int NIB_I0 = 2;
    localparam int NIB_Q1 = 1;
    localparam int NIB_Q0 = 0;

    typedef logic [SAMPLE_W-1:0] nibble_t;

    typedef struct packed {
        logic              sof;
        logic [BYTE_W-1:0] data;
    } entry_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    function automatic nibble_t pack_nibble(
        input logic i1,
        input logic i0,
        input logic q1,
        input logic q0
    );
        nibble_t n;
        n         = '0;
        n[NIB_I1] = i1;
        n[NIB_I0] = i0;
        n[NIB_Q1] = q1;
        n[NIB_Q0] = q0;
        return n;
    endfunction

endpackage

// File: rtl/gps_sync_fifo.sv
// Single-clock FIFO with count; push and pop may coincide.
// A push into a full FIFO is accepted only when a pop frees a slot.
module gps_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage clears so the head reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gps_sample_packer.sv
// Captures 2-bit I/Q samples, packs pairs into bytes, tags frame
// starts and queues bytes toward the downstream stage.
module gps_sample_packer
    import gps_bridge_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic        GPS_CLK_16_368,
    input  logic        RESET_N,
    input  logic        GPS_I0,
    input  logic        GPS_I1,
    input  logic        GPS_Q0,
    input  logic        GPS_Q1,
    input  logic        ENABLE,
    output logic [7:0]  DATA,
    output logic        DATA_SOF,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic        OVERFLOW,
    input  logic        OVF_CLR,
    output logic [15:0] DROP_COUNT
);

    localparam int FW = $clog2(FRAME_BYTES);
    localparam int CW = $clog2(DEPTH) + 1;

    nibble_t          smp_q;
    nibble_t          hold_q;
    phase_t           ph_q;
    phase_t           ph_d;
    logic             byte_vld;
    logic             hold_ld;
    logic [FW-1:0]    frame_q;
    entry_t           push_ent;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             drop;
    logic             ovf_q;
    logic [15:0]      drop_q;
    logic             unused_count;

    assign unused_count = ^fifo_count;

    // Input register: samples are captured every edge
    always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
        if (!RESET_N) begin
            smp_q <= '0;
        end else begin
            smp_q <= pack_nibble(GPS_I1, GPS_I0, GPS_Q1, GPS_Q0);
        end
    end

    // Packer phase register
    always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
        if (!RESET_N) begin
            ph_q <= PH_HI;
        end else begin
            ph_q <= ph_d;
        end
    end

    // Phase sequencing; disabling drops any half-built byte
    always_comb begin
        ph_d     = ph_q;
        byte_vld = 1'b0;
        hold_ld  = 1'b0;
        if (ENABLE) begin
            unique case (ph_q)
                PH_HI: begin
                    hold_ld = 1'b1;
                    ph_d    = PH_LO;
                end
                PH_LO: begin
                    byte_vld = 1'b1;
                    ph_d     = PH_HI;
                end
                default: ph_d = PH_HI;
            endcase
        end else begin
            ph_d = PH_HI;
        end
    end

    // High nibble holding register
    always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_q <= '0;
        end else if (hold_ld) begin
            hold_q <= smp_q;
        end
    end

    // Frame position advances on every formed byte, stored or dropped
    always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_q <= '0;
        end else if (byte_vld) begin
            if (frame_q == FW'(FRAME_BYTES - 1)) begin
                frame_q <= '0;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    assign push_ent.sof  = (frame_q == '0);
    assign push_ent.data = {hold_q, smp_q};

    // Full FIFO with no pop this edge cannot take the byte
    assign drop = byte_vld && fifo_full && !DATA_READY;

    // Drop statistics; a clear wins over a same-edge drop
    always_ff @(posedge GPS_CLK_16_368 or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (OVF_CLR) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    gps_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (GPS_CLK_16_368),
        .rst_n   (RESET_N),
        .push    (byte_vld),
        .wr_data (push_ent),
        .pop     (DATA_READY),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign DATA       = head.data;
    assign DATA_SOF   = head.sof;
    assign DATA_VALID = !fifo_empty;
    assign OVERFLOW   = ovf_q;
    assign DROP_COUNT = drop_q;

endmodule

// File: doc/gps_sample_packer.md
# gps_sample_packer

Capture stage at the front of the GPS-to-MCU bridge. Registers the MAX2769-style 2-bit I/Q sample stream (GPS_I1:I0, GPS_Q1:Q0) on the GPS sample clock and packs two consecutive samples into one byte. Tags the first byte of every frame. Buffers bytes in a small FIFO with a valid/ready handshake toward the downstream clock-crossing/SPI stage. Counts bytes lost to back-pressure.

## Interface
Parameters:
- DEPTH, 4: output FIFO depth in bytes; power of two, ≥2.
- FRAME_BYTES, 512: bytes per frame; DATA_SOF marks byte 0 of each frame; ≥2.

Ports:
- GPS_CLK_16_368, in, 1: sample clock, rising edge; only clock of this block.
- RESET_N, in, 1: asynchronous, active-low reset.
- GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, in, 1 each: front-end sample bits, synchronous to GPS_CLK_16_368.
- ENABLE, in, 1: capture enable.
- DATA, out, 8: packed byte, {I1,I0,Q1,Q0} of the earlier sample in [7:4], the later sample in [3:0].
- DATA_SOF, out, 1: DATA is byte 0 of a frame; qualified by DATA_VALID.
- DATA_VALID, out, 1: FIFO non-empty.
- DATA_READY, in, 1: consumer accepts DATA when DATA_VALID && DATA_READY at a rising edge.
- OVERFLOW, out, 1: sticky; set when a byte is dropped.
- OVF_CLR, in, 1: synchronous clear of OVERFLOW and DROP_COUNT.
- DROP_COUNT, out, 16: dropped-byte count, saturates at 16'hFFFF.

## Operation
- Input stage: the four GPS bits are registered every edge, regardless of ENABLE.
- Packer: 1-bit phase plus a 4-bit hold register.
  - When ENABLE is high: phase 0 latches the registered nibble into hold. Phase 1 forms byte {hold, nibble} and pushes it.
  - Phase toggles each enabled cycle.
  - When ENABLE is low: phase is forced to 0 and a half-built byte is discarded. Frame counter and FIFO are untouched.
- Frame counter: 0..FRAME_BYTES-1, wraps to 0.
  - Advances once per formed byte, whether the byte is stored or dropped, so frame alignment is preserved.
  - A byte formed while the counter is 0 carries SOF=1.
  - Stored entry width is 9 bits {SOF, byte}.
- FIFO: DEPTH entries with separate read and write pointers plus a count.
  - A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped: DROP_COUNT increments (saturating), OVERFLOW sets.
  - Simultaneous push and pop on an empty FIFO: the pop is invalid (DATA_VALID=0), so only the push occurs.
- OVF_CLR has priority over a same-cycle drop: both counter and flag go to 0. The drop in that cycle is not counted.
- Byte rate is one byte every 2 cycles, so the consumer must sustain DATA_READY ≥50% on average.

## Timing
- Reset values:
  - Outputs: DATA=0, DATA_SOF=0, DATA_VALID=0, OVERFLOW=0, DROP_COUNT=0.
  - Internal: phase=0, frame counter=0, FIFO empty, input register=0.
- Latency: a sample present before edge k is registered at k. If it is the second sample of a pair (phase 1 at k+1), it is pushed at edge k+1. DATA_VALID rises after edge k+1 when the FIFO was empty. This is a 2-edge input-to-output latency.
- DATA and DATA_SOF come directly from the FIFO head entry. They are stable while DATA_VALID && !DATA_READY.
- Reset asserted mid-operation: all state clears immediately. Queued bytes are lost and not counted as drops. After release, the first enabled cycle is phase 0 and the first byte carries SOF=1.
- ENABLE rising: the first sample captured at that edge's registered value is the high nibble of the next byte.

## Structure
- Shared package gps_bridge_pkg: nibble bit-order constant, SAMPLE_W=4, BYTE_W=8, default FRAME_BYTES. Downstream SPI and CDC stages reuse it.
- One sub-module: gps_sync_fifo (parameterised width/depth, single clock, async active-low reset, push/pop/full/empty/count).
- Packer, frame counter and drop statistics stay in gps_sample_packer.

## Test plan
- Reset then ENABLE=1 with DATA_READY=1. Drive samples I1I0Q1Q0 = 4'b1010, then 4'b0101 → DATA=8'hA5, DATA_SOF=1, DATA_VALID high 2 edges after the second sample; next byte has SOF=0.
- FRAME_BYTES=4 with a continuous ramp pattern → SOF on bytes 0, 4, 8; byte order and content match the ramp exactly.
- DATA_READY=0 for 20 cycles with DEPTH=4 → 4 bytes held unchanged; 6 bytes dropped; DROP_COUNT=6; OVERFLOW=1. Then OVF_CLR → both 0. SOF positions in subsequent bytes are unchanged by the drops.
- FIFO full with DATA_READY=1 on the push edge → push accepted, DROP_COUNT unchanged.
- ENABLE dropped after one sample of a pair, re-raised 3 cycles later → half byte discarded; next byte = {first new sample, second new sample}.
- RESET_N pulsed low mid-frame with 3 bytes queued → DATA_VALID=0 immediately; after release, first byte has SOF=1 and DROP_COUNT=0.
